// File: rtl/c_demux_pkg.sv
// Shared helpers for c_demux_bus_stream: select sizing, parameter legality and packed output width.
package c_demux_pkg;

  localparam int MIN_WIDTH   = 1;
  localparam int MAX_WIDTH   = 64;
  localparam int MIN_OUTPUTS = 2;
  localparam int MAX_OUTPUTS = 32;

  typedef enum int {
    LAT_DIRECT = 1,
    LAT_PIPE   = 2
  } latency_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic bit params_legal(input int width, input int outputs,
                                      input int sel_width, input int latency);
    return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
           (outputs >= MIN_OUTPUTS) && (outputs <= MAX_OUTPUTS) &&
           (sel_width >= clog2(outputs)) &&
           ((latency == int'(LAT_DIRECT)) || (latency == int'(LAT_PIPE)));
  endfunction

  function automatic int q_width(input int width, input int outputs);
    return width * outputs;
  endfunction

endpackage

// File: rtl/c_demux_out_slot.sv
// One-entry output holding register with valid/ready handshake; load must only be raised when free.
module c_demux_out_slot
  import c_demux_pkg::*;
#(
  parameter int           W     = 16,
  parameter logic [W-1:0] SINIT = '0
) (
  input  logic         clk,
  input  logic         aclr_n,
  input  logic         ce,
  input  logic         sclr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         q_ready,
  output logic [W-1:0] q,
  output logic         q_valid,
  output logic         free
);

  logic [W-1:0] data_reg;
  logic         valid_reg;

  // A drain and a refill can share an edge, so ready alone frees the slot.
  assign free    = ~valid_reg | q_ready;
  assign q       = data_reg;
  assign q_valid = valid_reg;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      valid_reg <= 1'b0;
      data_reg  <= SINIT;
    end else if (sclr) begin
      valid_reg <= 1'b0;
      data_reg  <= SINIT;
    end else if (ce) begin
      if (load) begin
        valid_reg <= 1'b1;
        data_reg  <= load_data;
      end else if (q_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/c_demux_bus_stream.sv
// Registered bus demultiplexer: routes each accepted word to one of C_OUTPUTS handshake slots.
// Optional broadcast input enabled by defining C_DEMUX_BUS_STREAM_BCAST_EN.
module c_demux_bus_stream
  import c_demux_pkg::*;
#(
  parameter int                 C_WIDTH     = 16,
  parameter int                 C_OUTPUTS   = 4,
  parameter int                 C_SEL_WIDTH = 2,
  parameter int                 C_LATENCY   = 1,
  parameter logic [C_WIDTH-1:0] C_SINIT_VAL = '0,
  localparam int                Q_W         = q_width(C_WIDTH, C_OUTPUTS)
) (
  input  logic                   CLK,
  input  logic                   ACLR_N,
  input  logic                   CE,
  input  logic                   SCLR,
  input  logic [C_WIDTH-1:0]     D,
  input  logic [C_SEL_WIDTH-1:0] S,
  input  logic                   D_VALID,
`ifdef C_DEMUX_BUS_STREAM_BCAST_EN
  input  logic                   BCAST,
`endif
  output logic                   D_READY,
  output logic [Q_W-1:0]         Q,
  output logic [C_OUTPUTS-1:0]   Q_VALID,
  input  logic [C_OUTPUTS-1:0]   Q_READY,
  output logic                   ERR
);

  localparam logic [C_SEL_WIDTH:0] SEL_LIMIT = (C_SEL_WIDTH + 1)'(C_OUTPUTS);

  if (!params_legal(C_WIDTH, C_OUTPUTS, C_SEL_WIDTH, C_LATENCY)) begin : g_bad_params
    $error("c_demux_bus_stream: illegal parameter combination");
  end

  logic                   bcast_in;
  logic                   st_valid;
  logic [C_WIDTH-1:0]     st_data;
  logic [C_SEL_WIDTH-1:0] st_sel;
  logic                   st_bcast;
  logic                   st_oor;
  logic                   st_go;
  logic                   advance;
  logic                   err_reg;
  logic [C_OUTPUTS-1:0]   slot_free;
  logic [C_OUTPUTS-1:0]   sel_hit;
  logic [C_OUTPUTS-1:0]   slot_load;

`ifdef C_DEMUX_BUS_STREAM_BCAST_EN
  assign bcast_in = BCAST;
`else
  assign bcast_in = 1'b0;
`endif

  // "st_*" is the word currently offered to the slots: raw input or the pipeline entry.
  always_comb begin
    st_oor = ~st_bcast & ($isunknown(st_sel) || ({1'b0, st_sel} >= SEL_LIMIT));
    if (st_bcast) st_go = &slot_free;
    else          st_go = st_oor | (|(sel_hit & slot_free));
  end

  assign advance = CE & ~SCLR & st_valid & st_go;

  for (genvar gi = 0; gi < C_OUTPUTS; gi++) begin : g_slot
    assign sel_hit[gi]   = (st_sel == C_SEL_WIDTH'(gi));
    assign slot_load[gi] = advance & ~st_oor & (st_bcast | sel_hit[gi]);

    c_demux_out_slot #(
      .W     (C_WIDTH),
      .SINIT (C_SINIT_VAL)
    ) u_slot (
      .clk       (CLK),
      .aclr_n    (ACLR_N),
      .ce        (CE),
      .sclr      (SCLR),
      .load      (slot_load[gi]),
      .load_data (st_data),
      .q_ready   (Q_READY[gi]),
      .q         (Q[gi*C_WIDTH +: C_WIDTH]),
      .q_valid   (Q_VALID[gi]),
      .free      (slot_free[gi])
    );
  end

  if (C_LATENCY == int'(LAT_PIPE)) begin : g_pipe
    logic                   p_valid_reg;
    logic [C_WIDTH-1:0]     p_data_reg;
    logic [C_SEL_WIDTH-1:0] p_sel_reg;
    logic                   p_bcast_reg;
    logic                   take;

    assign st_valid = p_valid_reg;
    assign st_data  = p_data_reg;
    assign st_sel   = p_sel_reg;
    assign st_bcast = p_bcast_reg;

    // Ready looks only at the held entry, never at the incoming D/S.
    assign D_READY = ACLR_N & CE & ~SCLR & (~p_valid_reg | st_go);
    assign take    = D_READY & D_VALID;

    always_ff @(posedge CLK or negedge ACLR_N) begin
      if (!ACLR_N) begin
        p_valid_reg <= 1'b0;
        p_data_reg  <= '0;
        p_sel_reg   <= '0;
        p_bcast_reg <= 1'b0;
      end else if (SCLR) begin
        p_valid_reg <= 1'b0;
      end else if (CE) begin
        if (take) begin
          p_valid_reg <= 1'b1;
          p_data_reg  <= D;
          p_sel_reg   <= S;
          p_bcast_reg <= bcast_in;
        end else if (advance) begin
          p_valid_reg <= 1'b0;
        end
      end
    end
  end else begin : g_direct
    assign st_valid = D_VALID;
    assign st_data  = D;
    assign st_sel   = S;
    assign st_bcast = bcast_in;
    assign D_READY  = ACLR_N & CE & ~SCLR & st_go;
  end

  always_ff @(posedge CLK or negedge ACLR_N) begin
    if (!ACLR_N)                err_reg <= 1'b0;
    else if (SCLR)              err_reg <= 1'b0;
    else if (advance && st_oor) err_reg <= 1'b1;
  end

  assign ERR = err_reg;

endmodule

// File: tb/tb_c_demux_bus_stream.sv
// Self-checking bench: a 3-output latency-1 and a 4-output latency-2 instance share one stimulus stream.
module tb_c_demux_bus_stream;

  localparam int          W      = 16;
  localparam int          N1     = 3;
  localparam int          N2     = 4;
  localparam logic [15:0] SINIT1 = 16'h0000;
  localparam logic [15:0] SINIT2 = 16'h00A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          aclr_n, ce, sclr, d_valid, bcast;
  logic [W-1:0]  din;
  logic [1:0]    sel;
  logic          rdy1, rdy2, err1, err2;
  logic [N1*W-1:0] q1;
  logic [N1-1:0] qv1, qr1;
  logic [N2*W-1:0] q2;
  logic [N2-1:0] qv2, qr2;

  int n_checks = 0;
  int n_pass   = 0;

  c_demux_bus_stream #(
    .C_WIDTH(W), .C_OUTPUTS(N1), .C_SEL_WIDTH(2), .C_LATENCY(1), .C_SINIT_VAL(SINIT1)
  ) dut_l1 (
    .CLK(clk), .ACLR_N(aclr_n), .CE(ce), .SCLR(sclr), .D(din), .S(sel), .D_VALID(d_valid),
`ifdef C_DEMUX_BUS_STREAM_BCAST_EN
    .BCAST(bcast),
`endif
    .D_READY(rdy1), .Q(q1), .Q_VALID(qv1), .Q_READY(qr1), .ERR(err1)
  );

  c_demux_bus_stream #(
    .C_WIDTH(W), .C_OUTPUTS(N2), .C_SEL_WIDTH(2), .C_LATENCY(2), .C_SINIT_VAL(SINIT2)
  ) dut_l2 (
    .CLK(clk), .ACLR_N(aclr_n), .CE(ce), .SCLR(sclr), .D(din), .S(sel), .D_VALID(d_valid),
`ifdef C_DEMUX_BUS_STREAM_BCAST_EN
    .BCAST(bcast),
`endif
    .D_READY(rdy2), .Q(q2), .Q_VALID(qv2), .Q_READY(qr2), .ERR(err2)
  );

  // Reference model, index k: 0 = latency-1 instance, 1 = latency-2 instance.
  int          n_out [2] = '{N1, N2};
  int          lat   [2] = '{1, 2};
  logic [15:0] sinit [2] = '{SINIT1, SINIT2};
  logic        m_qv  [2][4];
  logic [15:0] m_q   [2][4];
  logic        m_pv  [2];
  logic [15:0] m_pd  [2];
  int          m_ps  [2];
  logic        m_pb  [2];
  logic        m_err [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit qr_bit(int k, int i);
    if (k == 0) return qr1[i];
    return qr2[i];
  endfunction

  function automatic bit slot_free(int k, int i);
    return !m_qv[k][i] || qr_bit(k, i);
  endfunction

  function automatic bit all_free(int k);
    for (int i = 0; i < n_out[k]; i++)
      if (!slot_free(k, i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit target_ok(int k, bit bc, int s);
    if (bc) return all_free(k);
    if (s >= n_out[k]) return 1'b1;
    return slot_free(k, s);
  endfunction

  function automatic bit exp_ready(int k);
    if (!aclr_n || !ce || sclr) return 1'b0;
    if (lat[k] == 1) return target_ok(k, bcast, int'(sel));
    return !m_pv[k] || target_ok(k, m_pb[k], m_ps[k]);
  endfunction

  function automatic logic [63:0] exp_q(int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n_out[k]; i++) r[i*16 +: 16] = m_q[k][i];
    return r;
  endfunction

  function automatic logic [63:0] exp_qv(int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n_out[k]; i++) r[i] = m_qv[k][i];
    return r;
  endfunction

  task automatic model_reset(int k);
    for (int i = 0; i < 4; i++) begin
      m_qv[k][i] = 1'b0;
      m_q[k][i]  = sinit[k];
    end
    m_pv[k]  = 1'b0;
    m_err[k] = 1'b0;
  endtask

  // Applies one rising edge using the inputs that were stable before it.
  task automatic model_edge(int k);
    bit          acc, deliver, db;
    logic [15:0] dd;
    int          ds;
    if (!aclr_n || sclr) begin
      model_reset(k);
      return;
    end
    if (!ce) return;
    acc = exp_ready(k) && d_valid;
    if (lat[k] == 1) begin
      deliver = acc;  dd = din;  ds = int'(sel);  db = bcast;
    end else begin
      deliver = m_pv[k] && target_ok(k, m_pb[k], m_ps[k]);
      dd = m_pd[k];  ds = m_ps[k];  db = m_pb[k];
    end
    for (int i = 0; i < n_out[k]; i++)
      if (m_qv[k][i] && qr_bit(k, i)) m_qv[k][i] = 1'b0;
    if (deliver) begin
      if (db) begin
        for (int i = 0; i < n_out[k]; i++) begin
          m_qv[k][i] = 1'b1;
          m_q[k][i]  = dd;
        end
      end else if (ds >= n_out[k]) begin
        m_err[k] = 1'b1;
      end else begin
        m_qv[k][ds] = 1'b1;
        m_q[k][ds]  = dd;
      end
    end
    if (lat[k] == 2) begin
      if (acc) begin
        m_pv[k] = 1'b1;  m_pd[k] = din;  m_ps[k] = int'(sel);  m_pb[k] = bcast;
      end else if (deliver) begin
        m_pv[k] = 1'b0;
      end
    end
  endtask

  // Called just after a falling edge with inputs set; checks, then advances one clock.
  task automatic cycle();
    #1;
    chk("l1_ready", 64'(rdy1), 64'(exp_ready(0)));
    chk("l2_ready", 64'(rdy2), 64'(exp_ready(1)));
    chk("l1_qvalid", 64'(qv1), exp_qv(0));
    chk("l2_qvalid", 64'(qv2), exp_qv(1));
    chk("l1_q", 64'(q1), exp_q(0));
    chk("l2_q", 64'(q2), exp_q(1));
    chk("l1_err", 64'(err1), 64'(m_err[0]));
    chk("l2_err", 64'(err2), 64'(m_err[1]));
    if (d_valid && rdy1) $display("l1 accept d=%h s=%0d bcast=%0d", din, sel, bcast);
    if (d_valid && rdy2) $display("l2 accept d=%h s=%0d bcast=%0d", din, sel, bcast);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  // Drops ACLR_N between edges and expects every output cleared before the next edge.
  task automatic async_clear_check();
    #2 aclr_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    chk("aclr_l1_qvalid", 64'(qv1), exp_qv(0));
    chk("aclr_l2_qvalid", 64'(qv2), exp_qv(1));
    chk("aclr_l1_q", 64'(q1), exp_q(0));
    chk("aclr_l2_q", 64'(q2), exp_q(1));
    chk("aclr_l1_err", 64'(err1), 64'(0));
    chk("aclr_l2_err", 64'(err2), 64'(0));
    chk("aclr_l1_ready", 64'(rdy1), 64'(0));
    chk("aclr_l2_ready", 64'(rdy2), 64'(0));
    @(negedge clk);
    aclr_n = 1'b1;
  endtask

  initial begin
    aclr_n = 1'b0;  ce = 1'b1;  sclr = 1'b0;  d_valid = 1'b0;  bcast = 1'b0;
    din = '0;  sel = '0;  qr1 = '0;  qr2 = '0;
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    @(negedge clk);
    cycle();
    aclr_n = 1'b1;

    // Stream one word per channel with every consumer ready; S=3 is out of range on the 3-output instance.
    qr1 = '1;  qr2 = '1;  d_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 16'(i + 1);
      sel = 2'(i);
      cycle();
    end
    d_valid = 1'b0;
    repeat (3) cycle();
    sclr = 1'b1;
    cycle();
    sclr = 1'b0;
    cycle();

    // Channel 2 blocked: second word must wait, then arrive once ready returns.
    qr1 = 3'b011;  qr2 = 4'b1011;  d_valid = 1'b1;  sel = 2'd2;  din = 16'hAAAA;
    cycle();
    din = 16'hBBBB;
    repeat (3) cycle();
    d_valid = 1'b0;  qr1 = '1;  qr2 = '1;
    repeat (3) cycle();

    // CE low holds a full slot even with its consumer ready.
    qr1 = 3'b101;  qr2 = 4'b1101;  d_valid = 1'b1;  sel = 2'd1;  din = 16'h0077;
    repeat (2) cycle();
    d_valid = 1'b0;
    cycle();
    ce = 1'b0;  qr1 = '1;  qr2 = '1;  d_valid = 1'b1;  din = 16'h0099;
    repeat (5) cycle();
    ce = 1'b1;  d_valid = 1'b0;
    repeat (3) cycle();

`ifdef C_DEMUX_BUS_STREAM_BCAST_EN
    // Broadcast stalls behind a full slot 0, then lands on every channel at once.
    qr1 = '0;  qr2 = '0;  d_valid = 1'b1;  sel = 2'd0;  din = 16'h1111;
    cycle();
    bcast = 1'b1;  din = 16'h5A5A;
    repeat (3) cycle();
    qr1 = 3'b001;  qr2 = 4'b0001;
    cycle();
    bcast = 1'b0;  d_valid = 1'b0;
    repeat (2) cycle();
    qr1 = '1;  qr2 = '1;
    repeat (2) cycle();
`endif

    // Randomised traffic with an asynchronous reset dropped in mid-burst.
    for (int n = 0; n < 400; n++) begin
      ce      = ($urandom_range(0, 9) != 0);
      sclr    = ($urandom_range(0, 49) == 0);
      d_valid = ($urandom_range(0, 9) < 7);
      din     = 16'($urandom);
      sel     = 2'($urandom_range(0, 3));
      qr1     = 3'($urandom);
      qr2     = 4'($urandom);
`ifdef C_DEMUX_BUS_STREAM_BCAST_EN
      bcast   = ($urandom_range(0, 7) == 0);
`endif
      if (n == 200) async_clear_check();
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
